multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I datapath: fetch, decode, optional data-memory access, then a single commit cycle.
- Decodes op/f3/f7/zero from the datapath into its control inputs: branch, jump, resultSrc, regWrite, aluSrc, aluControl, csr_w, csr_inm, mocsr.
- Adds pcWrite (PC enable) and irWrite (instruction-register load) so that all architectural state changes only in the commit cycle.
- Owns the instruction-fetch and data-memory request/ready handshakes, and routes illegal instructions and memory timeouts to the exception vector (jump=11, address 100).

---
 rtl/multicycle_ctrl_pkg.sv | 77 +++++++
 rtl/multicycle_ctrl_if.sv | 20 ++
 rtl/multicycle_ctrl_alu_decoder.sv | 35 +++
 rtl/multicycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, control-field
// codes, FSM states, trap causes and the decoded-control bundle.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_ENV = 3'b000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_READ = 2'b01;
    localparam logic [1:0] RES_IMM  = 2'b10;
    localparam logic [1:0] RES_PC4  = 2'b11;

    localparam logic [1:0] JMP_RESET = 2'b00;
    localparam logic [1:0] JMP_NEXT  = 2'b01;
    localparam logic [1:0] JMP_PCIMM = 2'b10;
    localparam logic [1:0] JMP_EXC   = 2'b11;

    localparam logic [1:0] MOCSR_MEM = 2'b00;
    localparam logic [1:0] MOCSR_CSR = 2'b01;
    localparam logic [1:0] MOCSR_PC  = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_ECALL   = 2'b11;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic       branch;
        logic [1:0] jump;
        logic [1:0] result_src;
        logic       reg_write;
        logic       alu_src;
        logic [2:0] alu_control;
        logic       csr_w;
        logic       csr_inm;
        logic [1:0] mocsr;
        logic       mem_access;
        logic       mem_store;
        logic       illegal;
        logic       ecall;
    } dec_t;

    // Zicsr register/immediate forms: CSRRW, CSRRS, CSRRWI, CSRRSI
    function automatic logic is_csr_f3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b101) || (f3 == 3'b110);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-fetch and data-memory handshake between the controller (master)
// and the memory side (slave).
interface multicycle_ctrl_if;
    logic ifReq;
    logic ifReady;
    logic irWrite;
    logic memReq;
    logic memReady;
    logic memWe;

    modport master (
        output ifReq, irWrite, memReq, memWe,
        input  ifReady, memReady
    );

    modport slave (
        input  ifReq, irWrite, memReq, memWe,
        output ifReady, memReady
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation select for R/I-type and branches, with an illegal flag for
// unsupported funct3 values of those classes.
module multicycle_ctrl_alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic       f7,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (op)
            OP_R, OP_I: begin
                case (f3)
                    // instr[30] is an immediate bit for ADDI, so only R-type subtracts
                    F3_ADD:  alu_control = (op == OP_R && f7) ? ALU_SUB : ALU_ADD;
                    F3_AND:  alu_control = ALU_AND;
                    F3_OR:   alu_control = ALU_OR;
                    F3_SLT:  alu_control = ALU_SLT;
                    default: illegal     = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                alu_control = ALU_SUB;
                illegal     = (f3 != F3_BEQ) && (f3 != F3_BNE);
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: RST, FETCH, DECODE, optional MEM, then one
// commit cycle (WB or TRAP). CSR instructions are enabled by CTRL_ZICSR_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            f3,
    input  logic                  f7,
    input  logic                  zero,
    multicycle_ctrl_if.master     bus,
    output logic                  pcWrite,
    output logic                  regWrite,
    output logic                  csr_w,
    output logic                  csr_inm,
    output logic                  branch,
    output logic [1:0]            jump,
    output logic [1:0]            resultSrc,
    output logic [1:0]            mocsr,
    output logic                  aluSrc,
    output logic [2:0]            aluControl,
    output logic                  trap,
    output logic [1:0]            trapCause
);

    state_t           state_reg, state_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic [1:0]       trap_cause_reg, trap_cause_next;
    dec_t             dec;
    logic [2:0]       alu_ctl;
    logic             alu_illegal;
    logic             mem_timeout;
    logic             show_dec;

    multicycle_ctrl_alu_decoder u_alu_decoder (
        .op          (op),
        .f3          (f3),
        .f7          (f7),
        .alu_control (alu_ctl),
        .illegal     (alu_illegal)
    );

    // Instruction decode, purely from the latched instruction fields
    always_comb begin
        dec             = '0;
        dec.jump        = JMP_NEXT;
        dec.result_src  = RES_ALU;
        dec.mocsr       = MOCSR_MEM;
        dec.alu_control = alu_ctl;
        case (op)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.illegal   = alu_illegal;
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.illegal   = alu_illegal;
            end
            OP_LOAD: begin
                dec.alu_src    = 1'b1;
                dec.result_src = RES_READ;
                dec.reg_write  = 1'b1;
                dec.mem_access = 1'b1;
            end
            OP_STORE: begin
                dec.alu_src    = 1'b1;
                dec.mem_access = 1'b1;
                dec.mem_store  = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch  = (f3 == F3_BEQ) ? zero : ((f3 == F3_BNE) ? !zero : 1'b0);
                dec.illegal = alu_illegal;
            end
            OP_JAL: begin
                dec.jump       = JMP_PCIMM;
                dec.result_src = RES_PC4;
                dec.reg_write  = 1'b1;
            end
            OP_LUI: begin
                dec.result_src = RES_IMM;
                dec.reg_write  = 1'b1;
            end
            OP_SYSTEM: begin
                if (f3 == F3_ENV) begin
                    dec.ecall = 1'b1;
                end
`ifdef CTRL_ZICSR_EN
                else if (is_csr_f3(f3)) begin
                    dec.csr_w      = 1'b1;
                    dec.csr_inm    = f3[2];
                    dec.mocsr      = MOCSR_CSR;
                    dec.result_src = RES_READ;
                    dec.reg_write  = 1'b1;
                end
`endif
                else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign mem_timeout = (to_cnt_reg == TO_W'(MEM_TIMEOUT - 1));
    assign trapCause   = trap_cause_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_RST;
            to_cnt_reg     <= '0;
            trap_cause_reg <= CAUSE_NONE;
        end else begin
            state_reg      <= state_next;
            to_cnt_reg     <= to_cnt_next;
            trap_cause_reg <= trap_cause_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        to_cnt_next     = '0;
        trap_cause_next = trap_cause_reg;
        show_dec        = 1'b0;
        bus.ifReq       = 1'b0;
        bus.irWrite     = 1'b0;
        bus.memReq      = 1'b0;
        bus.memWe       = 1'b0;
        pcWrite         = 1'b0;
        regWrite        = 1'b0;
        csr_w           = 1'b0;
        csr_inm         = 1'b0;
        branch          = 1'b0;
        jump            = JMP_RESET;
        resultSrc       = RES_ALU;
        mocsr           = MOCSR_MEM;
        aluSrc          = 1'b0;
        aluControl      = ALU_ADD;
        trap            = 1'b0;

        case (state_reg)
            ST_RST: begin
                // State is forced to RST while rst_n is low; keep PC frozen then
                pcWrite    = rst_n;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                jump      = JMP_NEXT;
                bus.ifReq = 1'b1;
                if (bus.ifReady) begin
                    bus.irWrite = 1'b1;
                    state_next  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                show_dec = 1'b1;
                if (dec.illegal) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = CAUSE_ILLEGAL;
                end else if (dec.ecall) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = CAUSE_ECALL;
                end else if (dec.mem_access) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                show_dec   = 1'b1;
                bus.memReq = 1'b1;
                bus.memWe  = dec.mem_store;
                // memReady has priority over an expiring timeout
                if (bus.memReady) begin
                    state_next = ST_WB;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                    if (mem_timeout) begin
                        state_next      = ST_TRAP;
                        trap_cause_next = CAUSE_TIMEOUT;
                    end
                end
            end
            ST_WB: begin
                show_dec   = 1'b1;
                pcWrite    = 1'b1;
                regWrite   = dec.reg_write;
                csr_w      = dec.csr_w;
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                jump       = JMP_EXC;
                pcWrite    = 1'b1;
                trap       = 1'b1;
                state_next = ST_FETCH;
            end
            default: state_next = ST_RST;
        endcase

        if (show_dec) begin
            branch     = dec.branch;
            jump       = dec.jump;
            resultSrc  = dec.result_src;
            mocsr      = dec.mocsr;
            aluSrc     = dec.alu_src;
            aluControl = dec.alu_control;
            csr_inm    = dec.csr_inm;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected commit of
// each instruction, a monitor pops and checks on every pcWrite cycle.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 15;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    logic       pcWrite, regWrite, csr_w, csr_inm, branch, aluSrc, trap;
    logic [1:0] jump, resultSrc, mocsr, trapCause;
    logic [2:0] aluControl;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .f3         (f3),
        .f7         (f7),
        .zero       (zero),
        .bus        (bus),
        .pcWrite    (pcWrite),
        .regWrite   (regWrite),
        .csr_w      (csr_w),
        .csr_inm    (csr_inm),
        .branch     (branch),
        .jump       (jump),
        .resultSrc  (resultSrc),
        .mocsr      (mocsr),
        .aluSrc     (aluSrc),
        .aluControl (aluControl),
        .trap       (trap),
        .trapCause  (trapCause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         is_rst;
        bit         is_trap;
        logic [1:0] tcause;
        logic [1:0] jump;
        bit         reg_write;
        logic [2:0] alu;
        bit         alu_src;
        logic [1:0] res;
        logic [1:0] mocsr;
        bit         branch;
        bit         csr_w;
        bit         csr_inm;
        bit         is_store;
        int         mem_cycles;
    } exp_t;

    exp_t       q[$];
    int         tests = 0;
    int         fails = 0;
    logic [1:0] last_cause = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t blank(input string nm);
        exp_t e;
        e.name = nm; e.is_rst = 0; e.is_trap = 0; e.tcause = 0; e.jump = 2'b01;
        e.reg_write = 0; e.alu = 0; e.alu_src = 0; e.res = 0; e.mocsr = 0;
        e.branch = 0; e.csr_w = 0; e.csr_inm = 0; e.is_store = 0; e.mem_cycles = 0;
        return e;
    endfunction

    // Reference: what the commit cycle of one instruction must look like
    function automatic exp_t model(input string nm, input logic [6:0] o, input logic [2:0] f,
                                   input logic g, input logic z, input int md);
        exp_t e;
        bit bad = 0;
        bit env = 0;
        bit mem = 0;
        e = blank(nm);
        case (o)
            7'b0110011, 7'b0010011: begin
                e.reg_write = 1;
                e.alu_src = (o == 7'b0010011);
                if (f == 3'd0)      e.alu = (o == 7'b0110011 && g) ? 3'd1 : 3'd0;
                else if (f == 3'd7) e.alu = 3'd2;
                else if (f == 3'd6) e.alu = 3'd3;
                else if (f == 3'd2) e.alu = 3'd5;
                else bad = 1;
            end
            7'b0000011: begin e.alu_src = 1; e.res = 2'd1; e.reg_write = 1; mem = 1; end
            7'b0100011: begin e.alu_src = 1; e.is_store = 1; mem = 1; end
            7'b1100011: begin
                e.alu = 3'd1;
                if (f == 3'd0)      e.branch = z;
                else if (f == 3'd1) e.branch = !z;
                else bad = 1;
            end
            7'b1101111: begin e.jump = 2'd2; e.res = 2'd3; e.reg_write = 1; end
            7'b0110111: begin e.res = 2'd2; e.reg_write = 1; end
            7'b1110011: begin
                if (f == 3'd0) env = 1;
`ifdef CTRL_ZICSR_EN
                else if (f == 3'd1 || f == 3'd2 || f == 3'd5 || f == 3'd6) begin
                    e.csr_w = 1; e.csr_inm = f[2]; e.mocsr = 2'd1; e.res = 2'd1; e.reg_write = 1;
                end
`endif
                else bad = 1;
            end
            default: bad = 1;
        endcase
        if (bad) begin
            e.is_trap = 1; e.tcause = 2'd1;
        end else if (env) begin
            e.is_trap = 1; e.tcause = 2'd3;
        end else if (mem) begin
            if (md < TIMEOUT) e.mem_cycles = md + 1;
            else begin e.is_trap = 1; e.tcause = 2'd2; e.mem_cycles = TIMEOUT; end
        end
        return e;
    endfunction

    // Monitor: every pcWrite cycle is one commit (reset, WB or TRAP)
    initial begin
        int  memcnt = 0;
        bit  memwe_any = 0;
        bit  trap_prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                memcnt = 0; memwe_any = 0; trap_prev = 0;
            end else begin
                if (trap_prev) check("fetch_after_trap", bus.ifReq, 1);
                trap_prev = trap;
                if (bus.memReq) begin
                    memcnt++;
                    if (bus.memWe) memwe_any = 1;
                end
                if (pcWrite) begin
                    if (q.size() == 0) begin
                        check("unexpected_commit", pcWrite, 0);
                    end else begin
                        e = q.pop_front();
                        check({e.name, "_trapCause"}, trapCause, e.tcause);
                        if (e.is_rst) begin
                            check("rst_jump", jump, 0);
                            check("rst_regWrite", regWrite, 0);
                            check("rst_trap", trap, 0);
                        end else begin
                            check({e.name, "_trap"}, trap, e.is_trap);
                            check({e.name, "_memcyc"}, memcnt, e.mem_cycles);
                            check({e.name, "_memWe"}, memwe_any, e.is_store);
                            check({e.name, "_regWrite"}, regWrite, e.is_trap ? 0 : e.reg_write);
                            check({e.name, "_csr_w"}, csr_w, e.is_trap ? 0 : e.csr_w);
                            check({e.name, "_jump"}, jump, e.is_trap ? 2'd3 : e.jump);
                            if (!e.is_trap) begin
                                check({e.name, "_alu"}, aluControl, e.alu);
                                check({e.name, "_aluSrc"}, aluSrc, e.alu_src);
                                check({e.name, "_resultSrc"}, resultSrc, e.res);
                                check({e.name, "_mocsr"}, mocsr, e.mocsr);
                                check({e.name, "_branch"}, branch, e.branch);
                                check({e.name, "_csr_inm"}, csr_inm, e.csr_inm);
                            end
                        end
                        $display("[TB] %-8s %s cause=%0d memcyc=%0d", e.name,
                                 e.is_rst ? "reset" : (e.is_trap ? "trap" : "commit"),
                                 trapCause, memcnt);
                    end
                    memcnt = 0;
                    memwe_any = 0;
                end
            end
        end
    end

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_pcWrite", pcWrite, 0);
        check("rst_ifReq", bus.ifReq, 0);
        check("rst_memReq", bus.memReq, 0);
        check("rst_jump_low", jump, 0);
        check("rst_regWrite_low", regWrite, 0);
        repeat (2) @(negedge clk);
        check("rst_trapCause", trapCause, 0);
        last_cause = 2'b00;
        e = blank("RESET");
        e.is_rst = 1;
        q.push_back(e);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic present(input logic [6:0] o, input logic [2:0] f, input logic g,
                           input logic z, input int fd, output bit ok);
        int guard = 0;
        ok = 0;
        while (bus.ifReq !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (bus.ifReq !== 1'b1) begin
            check("ifReq_wait", bus.ifReq, 1);
            return;
        end
        repeat (fd) @(negedge clk);
        op = o; f3 = f; f7 = g; zero = z;
        bus.ifReady = 1'b1;
        #1 check("irWrite", bus.irWrite, 1);
        @(negedge clk);
        bus.ifReady = 1'b0;
        ok = 1;
    endtask

    task automatic wait_memreq(output bit ok);
        int guard = 0;
        while (bus.memReq !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        ok = (bus.memReq === 1'b1);
        if (!ok) check("memReq_wait", bus.memReq, 1);
    endtask

    task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f,
                             input logic g, input logic z, input int fd, input int md);
        exp_t e;
        bit ok;
        e = model(nm, o, f, g, z, md);
        if (e.is_trap) last_cause = e.tcause;
        e.tcause = last_cause;
        present(o, f, g, z, fd, ok);
        if (!ok) return;
        q.push_back(e);
        if (e.mem_cycles > 0) begin
            wait_memreq(ok);
            if (ok && md < TIMEOUT) begin
                repeat (md) @(negedge clk);
                bus.memReady = 1'b1;
                @(negedge clk);
                bus.memReady = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cls, fd, md;
        logic [6:0] o;
        logic [2:0] f;
        logic [6:0] illegal_ops [3];
        illegal_ops[0] = 7'b0010111;
        illegal_ops[1] = 7'b1100111;
        illegal_ops[2] = 7'b0001111;

        rst_n = 1'b0; op = '0; f3 = '0; f7 = 1'b0; zero = 1'b0;
        bus.ifReady = 1'b0; bus.memReady = 1'b0;
        do_reset();

        run_instr("ADD",    7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("SUB",    7'b0110011, 3'b000, 1'b1, 1'b0, 1, 0);
        run_instr("LW",     7'b0000011, 3'b010, 1'b0, 1'b0, 1, 2);
        run_instr("SW_TO",  7'b0100011, 3'b010, 1'b0, 1'b0, 0, 99);
        run_instr("BEQ",    7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr("BNE",    7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);
        run_instr("AUIPC",  7'b0010111, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("ECALL",  7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("CSRRWI", 7'b1110011, 3'b101, 1'b0, 1'b0, 0, 0);
        run_instr("JAL",    7'b1101111, 3'b011, 1'b0, 1'b0, 2, 0);
        run_instr("SW14",   7'b0100011, 3'b000, 1'b0, 1'b0, 0, 14);
        run_instr("LW15",   7'b0000011, 3'b000, 1'b0, 1'b0, 0, 15);

        // Reset in the middle of a data access: the load never commits
        present(7'b0000011, 3'b010, 1'b0, 1'b0, 0, ok);
        if (ok) begin
            wait_memreq(ok);
            repeat (3) @(negedge clk);
        end
        do_reset();
        run_instr("ADD2",   7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            cls = $urandom_range(0, 9);
            f   = 3'($urandom_range(0, 7));
            case (cls)
                0: o = 7'b0110011;
                1: o = 7'b0010011;
                2: o = 7'b0000011;
                3: o = 7'b0100011;
                4: o = 7'b1100011;
                5: o = 7'b1101111;
                6: o = 7'b0110111;
                7: o = 7'b1110011;
                8: o = illegal_ops[$urandom_range(0, 2)];
                default: o = 7'($urandom);
            endcase
            fd = $urandom_range(0, 3);
            md = ($urandom_range(0, 4) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 4);
            run_instr($sformatf("R%0d", n), o, f, 1'($urandom), 1'($urandom), fd, md);
        end

        for (int g = 0; g < 100 && q.size() != 0; g++) @(negedge clk);
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
